// File: rtl/alien_move_scheduler_pkg.sv
// Shared definitions for the alien move scheduler: motion codes, FSM
// state encoding and default screen limits.
package alien_move_scheduler_pkg;

    localparam logic [2:0] MOT_NONE  = 3'b000;
    localparam logic [2:0] MOT_LEFT  = 3'b001;
    localparam logic [2:0] MOT_RIGHT = 3'b010;
    localparam logic [2:0] MOT_DOWN  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_GRANT     = 2'd2,
        ST_SAMPLE    = 2'd3
    } sched_state_t;

    localparam int DEF_X_MIN   = 0;
    localparam int DEF_X_MAX   = 200;
    localparam int DEF_Y_LIMIT = 160;

endpackage

// File: rtl/alien_move_scheduler_pos_reg.sv
// alien_pos_reg: position register for one alien.
// Ports:
//   clk, reset (async, active-low)
//   i_apply      - apply i_motion at this clock edge
//   i_motion     - 3-bit motion code
//   o_x, o_y     - registered position
//   o_can_left/o_can_right - move feasibility from registered x
//   o_illegal    - i_apply with an illegal code or blocked move
//   o_hit        - i_apply and the updated y reaches Y_LIMIT
module alien_pos_reg
    import alien_move_scheduler_pkg::*;
#(
    parameter int X_MIN   = DEF_X_MIN,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int STEP_X  = 4,
    parameter int STEP_Y  = 8,
    parameter int Y_LIMIT = DEF_Y_LIMIT,
    parameter int X_INIT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_apply,
    input  logic [2:0] i_motion,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic       o_can_left,
    output logic       o_can_right,
    output logic       o_illegal,
    output logic       o_hit
);

    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] w_x_next;
    logic [7:0] w_y_next;
    logic [8:0] w_y_sum;
    logic       w_bad;

    assign o_x = r_x;
    assign o_y = r_y;

    // 9-bit compares so x+STEP_X cannot wrap past 255
    assign o_can_left  = {1'b0, r_x} >= 9'(X_MIN + STEP_X);
    assign o_can_right = ({1'b0, r_x} + 9'(STEP_X)) <= 9'(X_MAX);
    assign w_y_sum     = {1'b0, r_y} + 9'(STEP_Y);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        w_bad    = 1'b0;
        case (i_motion)
            MOT_NONE: begin
            end
            MOT_LEFT: begin
                if (o_can_left) w_x_next = r_x - 8'(STEP_X);
                else            w_bad    = 1'b1;
            end
            MOT_RIGHT: begin
                if (o_can_right) w_x_next = r_x + 8'(STEP_X);
                else             w_bad    = 1'b1;
            end
            MOT_DOWN: begin
                w_y_next = w_y_sum[8] ? 8'hFF : w_y_sum[7:0];
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign o_illegal = i_apply & w_bad;
    assign o_hit     = i_apply & ({1'b0, w_y_next} >= 9'(Y_LIMIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= 8'(X_INIT);
            r_y <= 8'd0;
        end else if (i_apply) begin
            r_x <= w_x_next;
            r_y <= w_y_next;
        end
    end

endmodule

// File: rtl/alien_move_scheduler.sv
// alien_move_scheduler: once per movement frame, grants each alive alien
// one enable cycle (round-robin start) and applies its motion code.
// Ports:
//   clk, reset (async, active-low), run (enable)
//   alive_i, motion_i        - per-alien alive flag / 3-bit motion code
//   enable_o                 - one-hot grant, one cycle per alien
//   can_left_o, can_right_o  - per-alien move feasibility
//   x_o, y_o                 - packed 8-bit positions
//   busy_o, frame_done_o, illegal_o, invaded_o
//
// state     | meaning
// IDLE      | stopped, waiting for run
// WAIT_TICK | counting TICK_DIV cycles to the next frame
// GRANT     | enable_o asserted for current alien
// SAMPLE    | motion of current alien applied at the end of this cycle
module alien_move_scheduler
    import alien_move_scheduler_pkg::*;
#(
    parameter int N_ALIEN        = 4,
    parameter int TICK_DIV       = 1000,
    parameter int X_MIN          = DEF_X_MIN,
    parameter int X_MAX          = DEF_X_MAX,
    parameter int STEP_X         = 4,
    parameter int STEP_Y         = 8,
    parameter int Y_LIMIT        = DEF_Y_LIMIT,
    parameter int X_INIT_SPACING = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [N_ALIEN-1:0]     alive_i,
    input  logic [3*N_ALIEN-1:0]   motion_i,
    output logic [N_ALIEN-1:0]     enable_o,
    output logic [N_ALIEN-1:0]     can_left_o,
    output logic [N_ALIEN-1:0]     can_right_o,
    output logic [8*N_ALIEN-1:0]   x_o,
    output logic [8*N_ALIEN-1:0]   y_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   illegal_o,
    output logic                   invaded_o
);

    localparam int IW = (N_ALIEN > 1) ? $clog2(N_ALIEN) : 1;
    localparam int CW = $clog2(TICK_DIV + 1);

    sched_state_t      r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_start;
    logic [IW-1:0]     r_off;
    logic [IW-1:0]     r_grant;
    logic              r_stop;

    logic              w_found;
    logic [IW-1:0]     w_off;
    logic [IW-1:0]     w_idx;
    logic [IW-1:0]     w_start_next;
    logic [N_ALIEN-1:0] w_onehot;
    logic [N_ALIEN-1:0] w_apply;
    logic [N_ALIEN-1:0] w_illegal;
    logic [N_ALIEN-1:0] w_hit;

    // First alive alien at scan offset >= base; offset 0 at frame start,
    // one past the current alien while sampling.
    always_comb begin
        int v_base;
        int v_idx;
        v_base  = (r_state == ST_SAMPLE) ? int'(r_off) + 1 : 0;
        v_idx   = 0;
        w_found = 1'b0;
        w_off   = '0;
        w_idx   = '0;
        for (int k = N_ALIEN - 1; k >= 0; k--) begin
            v_idx = int'(r_start) + k;
            if (v_idx >= N_ALIEN) v_idx = v_idx - N_ALIEN;
            if (k >= v_base && alive_i[IW'(v_idx)]) begin
                w_found = 1'b1;
                w_off   = IW'(k);
                w_idx   = IW'(v_idx);
            end
        end
    end

    assign w_onehot     = N_ALIEN'(1) << w_idx;
    assign w_start_next = (r_start == IW'(N_ALIEN - 1)) ? '0 : r_start + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_start      <= '0;
            r_off        <= '0;
            r_grant      <= '0;
            r_stop       <= 1'b0;
            enable_o     <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            enable_o     <= '0;
            frame_done_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_WAIT_TICK;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CW'(TICK_DIV - 1)) begin
                        r_cnt <= '0;
                        if (w_found) begin
                            r_state  <= ST_GRANT;
                            r_grant  <= w_idx;
                            r_off    <= w_off;
                            r_stop   <= 1'b0;
                            enable_o <= w_onehot;
                            busy_o   <= 1'b1;
                        end else begin
                            frame_done_o <= 1'b1;
                            r_start      <= w_start_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GRANT: begin
                    r_state <= ST_SAMPLE;
                    // remember a stop request so the alien still completes
                    if (!run) r_stop <= 1'b1;
                end
                ST_SAMPLE: begin
                    if (!run || r_stop) begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (w_found) begin
                        r_state  <= ST_GRANT;
                        r_grant  <= w_idx;
                        r_off    <= w_off;
                        enable_o <= w_onehot;
                    end else begin
                        r_state      <= ST_WAIT_TICK;
                        r_cnt        <= '0;
                        busy_o       <= 1'b0;
                        frame_done_o <= 1'b1;
                        r_start      <= w_start_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_o <= 1'b0;
            invaded_o <= 1'b0;
        end else begin
            illegal_o <= |w_illegal;
            if (|w_hit) invaded_o <= 1'b1;
        end
    end

    for (genvar i = 0; i < N_ALIEN; i++) begin : g_alien
        assign w_apply[i] = (r_state == ST_SAMPLE) && (r_grant == IW'(i));

        alien_pos_reg #(
            .X_MIN   (X_MIN),
            .X_MAX   (X_MAX),
            .STEP_X  (STEP_X),
            .STEP_Y  (STEP_Y),
            .Y_LIMIT (Y_LIMIT),
            .X_INIT  (i * X_INIT_SPACING)
        ) u_pos (
            .clk         (clk),
            .reset       (reset),
            .i_apply     (w_apply[i]),
            .i_motion    (motion_i[3*i +: 3]),
            .o_x         (x_o[8*i +: 8]),
            .o_y         (y_o[8*i +: 8]),
            .o_can_left  (can_left_o[i]),
            .o_can_right (can_right_o[i]),
            .o_illegal   (w_illegal[i]),
            .o_hit       (w_hit[i])
        );
    end

endmodule
